// File: rtl/decode_stage.sv
// Decode stage of a five-stage RV32I-subset pipeline: register file with
// write-through bypass, control/immediate decode, and the D/E pipeline register.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    input  logic        FlushE,
    output logic        RegWriteE,
    output logic [1:0]  ResultSrcE,
    output logic        MemWriteE,
    output logic        JumpE,
    output logic        BranchE,
    output logic [2:0]  ALUControlE,
    output logic        ALUSrcE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic [4:0]  RdE,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E
);

    localparam logic [6:0] OP_R    = 7'h33;
    localparam logic [6:0] OP_I    = 7'h13;
    localparam logic [6:0] OP_LW   = 7'h03;
    localparam logic [6:0] OP_SW   = 7'h23;
    localparam logic [6:0] OP_BEQ  = 7'h63;
    localparam logic [6:0] OP_JAL  = 7'h6F;

    logic [31:0] rf_q [0:31];

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rs1, rs2, rd;
    logic        wr_en;

    logic        reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
    logic [1:0]  result_src_d;
    logic [2:0]  alu_ctrl_d;
    logic [31:0] imm_d, rd1_d, rd2_d;

    logic        reg_write_q, mem_write_q, jump_q, branch_q, alu_src_q;
    logic [1:0]  result_src_q;
    logic [2:0]  alu_ctrl_q;
    logic [31:0] rd1_q, rd2_q, imm_q, pc_q, pc_plus4_q;
    logic [4:0]  rs1_q, rs2_q, rd_q;

    assign opcode   = InstrD[6:0];
    assign funct3   = InstrD[14:12];
    assign funct7b5 = InstrD[30];
    assign rs1      = InstrD[19:15];
    assign rs2      = InstrD[24:20];
    assign rd       = InstrD[11:7];
    assign wr_en    = reset && RegWriteW && (RdW != 5'd0);

    function automatic logic [2:0] alu_map(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  alu_map = sub ? 3'b001 : 3'b000;
            3'b111:  alu_map = 3'b010;
            3'b110:  alu_map = 3'b011;
            3'b010:  alu_map = 3'b101;
            default: alu_map = 3'b000;
        endcase
    endfunction

    // x0 is hardwired; a same-cycle writeback to the read index wins over the array.
    function automatic logic [31:0] rf_read(input logic [4:0] idx, input logic [31:0] stored);
        if (idx == 5'd0)
            rf_read = 32'd0;
        else if (wr_en && (RdW == idx))
            rf_read = ResultW;
        else
            rf_read = stored;
    endfunction

    assign rd1_d = rf_read(rs1, rf_q[rs1]);
    assign rd2_d = rf_read(rs2, rf_q[rs2]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else if (wr_en) begin
            rf_q[RdW] <= ResultW;
        end
    end

    always_comb begin
        reg_write_d  = 1'b0;
        result_src_d = 2'b00;
        mem_write_d  = 1'b0;
        jump_d       = 1'b0;
        branch_d     = 1'b0;
        alu_ctrl_d   = 3'b000;
        alu_src_d    = 1'b0;
        // Unrecognised opcodes still carry the I-format immediate as data.
        imm_d        = {{20{InstrD[31]}}, InstrD[31:20]};
        case (opcode)
            OP_R: begin
                reg_write_d = 1'b1;
                alu_ctrl_d  = alu_map(funct3, funct7b5);
            end
            OP_I: begin
                reg_write_d = 1'b1;
                alu_src_d   = 1'b1;
                alu_ctrl_d  = alu_map(funct3, 1'b0);
            end
            OP_LW: begin
                reg_write_d  = 1'b1;
                alu_src_d    = 1'b1;
                result_src_d = 2'b01;
            end
            OP_SW: begin
                mem_write_d = 1'b1;
                alu_src_d   = 1'b1;
                imm_d       = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            end
            OP_BEQ: begin
                branch_d   = 1'b1;
                alu_ctrl_d = 3'b001;
                imm_d      = {{19{InstrD[31]}}, InstrD[31], InstrD[7],
                              InstrD[30:25], InstrD[11:8], 1'b0};
            end
            OP_JAL: begin
                jump_d       = 1'b1;
                reg_write_d  = 1'b1;
                result_src_d = 2'b10;
                imm_d        = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12],
                                InstrD[20], InstrD[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset || FlushE) begin
            reg_write_q  <= 1'b0;
            result_src_q <= 2'b00;
            mem_write_q  <= 1'b0;
            jump_q       <= 1'b0;
            branch_q     <= 1'b0;
            alu_ctrl_q   <= 3'b000;
            alu_src_q    <= 1'b0;
            rd1_q        <= 32'd0;
            rd2_q        <= 32'd0;
            imm_q        <= 32'd0;
            rs1_q        <= 5'd0;
            rs2_q        <= 5'd0;
            rd_q         <= 5'd0;
            pc_q         <= 32'd0;
            pc_plus4_q   <= 32'd0;
        end else begin
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            mem_write_q  <= mem_write_d;
            jump_q       <= jump_d;
            branch_q     <= branch_d;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_src_q    <= alu_src_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            imm_q        <= imm_d;
            rs1_q        <= rs1;
            rs2_q        <= rs2;
            rd_q         <= rd;
            pc_q         <= PCD;
            pc_plus4_q   <= PCPlus4D;
        end
    end

    assign RegWriteE   = reg_write_q;
    assign ResultSrcE  = result_src_q;
    assign MemWriteE   = mem_write_q;
    assign JumpE       = jump_q;
    assign BranchE     = branch_q;
    assign ALUControlE = alu_ctrl_q;
    assign ALUSrcE     = alu_src_q;
    assign RD1E        = rd1_q;
    assign RD2E        = rd2_q;
    assign ImmExtE     = imm_q;
    assign Rs1E        = rs1_q;
    assign Rs2E        = rs2_q;
    assign RdE         = rd_q;
    assign PCE         = pc_q;
    assign PCPlus4E    = pc_plus4_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: hand-encoded instructions,
// hand-computed register-file contents, immediates and control fields.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_d, pc_d, pc_plus4_d;
    logic        reg_write_w;
    logic [4:0]  rd_w;
    logic [31:0] result_w;
    logic        flush_e;
    logic        reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e;
    logic [1:0]  result_src_e;
    logic [2:0]  alu_ctrl_e;
    logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;

    int checks = 0;
    int errors = 0;

    decode_stage dut (
        .clk(clk), .reset(reset), .InstrD(instr_d), .PCD(pc_d), .PCPlus4D(pc_plus4_d),
        .RegWriteW(reg_write_w), .RdW(rd_w), .ResultW(result_w), .FlushE(flush_e),
        .RegWriteE(reg_write_e), .ResultSrcE(result_src_e), .MemWriteE(mem_write_e),
        .JumpE(jump_e), .BranchE(branch_e), .ALUControlE(alu_ctrl_e), .ALUSrcE(alu_src_e),
        .RD1E(rd1_e), .RD2E(rd2_e), .ImmExtE(imm_e), .Rs1E(rs1_e), .Rs2E(rs2_e),
        .RdE(rd_e), .PCE(pc_e), .PCPlus4E(pc_plus4_e)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs are set between edges; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic we, input logic [4:0] rd,
                         input logic [31:0] res);
        instr_d     = instr;
        reg_write_w = we;
        rd_w        = rd;
        result_w    = res;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ctrl"}, {25'd0, reg_write_e, result_src_e, mem_write_e, jump_e,
                               branch_e, alu_src_e}, 32'd0);
        check({tag, ".aluctl"}, {29'd0, alu_ctrl_e}, 32'd0);
        check({tag, ".rd1"}, rd1_e, 32'd0);
        check({tag, ".rd2"}, rd2_e, 32'd0);
        check({tag, ".imm"}, imm_e, 32'd0);
        check({tag, ".regs"}, {17'd0, rs1_e, rs2_e, rd_e}, 32'd0);
        check({tag, ".pc"}, pc_e, 32'd0);
        check({tag, ".pc4"}, pc_plus4_e, 32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        flush_e    = 1'b0;
        pc_d       = 32'h40;
        pc_plus4_d = 32'h44;
        // Reset edge: a write attempt to x5 must be blocked.
        drive(32'h005283B3, 1'b1, 5'd5, 32'h0000_1111);
        step();
        check_all_zero("reset");

        reset = 1'b1;
        drive(32'h00502333, 1'b0, 5'd0, 32'd0);
        step();
        check("post_reset.rd2", rd2_e, 32'd0);
        check("post_reset.regwrite", {31'd0, reg_write_e}, 32'd1);
        check("post_reset.rd", {27'd0, rd_e}, 32'd6);

        // Write x5 while decoding an all-zero bubble.
        drive(32'h0000_0000, 1'b1, 5'd5, 32'hDEADBEEF);
        pc_d = 32'h40; pc_plus4_d = 32'h44;
        step();
        check("bubble.ctrl", {24'd0, reg_write_e, result_src_e, mem_write_e, jump_e,
                              branch_e, alu_src_e, 1'b0}, 32'd0);
        check("bubble.aluctl", {29'd0, alu_ctrl_e}, 32'd0);
        check("bubble.pc", pc_e, 32'h40);
        check("bubble.pc4", pc_plus4_e, 32'h44);

        drive(32'h005283B3, 1'b0, 5'd0, 32'd0);
        pc_d = 32'h100; pc_plus4_d = 32'h104;
        step();
        check("add.rd1", rd1_e, 32'hDEADBEEF);
        check("add.rd2", rd2_e, 32'hDEADBEEF);
        check("add.regwrite", {31'd0, reg_write_e}, 32'd1);
        check("add.aluctl", {29'd0, alu_ctrl_e}, 32'd0);
        check("add.alusrc", {31'd0, alu_src_e}, 32'd0);
        check("add.rd", {27'd0, rd_e}, 32'd7);
        check("add.rs1", {27'd0, rs1_e}, 32'd5);
        check("add.rs2", {27'd0, rs2_e}, 32'd5);
        check("add.pc", pc_e, 32'h100);
        check("add.pc4", pc_plus4_e, 32'h104);

        drive(32'h005283B3, 1'b1, 5'd5, 32'h12345678);
        step();
        check("bypass.rd1", rd1_e, 32'h12345678);
        check("bypass.rd2", rd2_e, 32'h12345678);

        // add x6,x0,x0 while writing x0: neither the array nor the bypass may leak.
        drive(32'h00000333, 1'b1, 5'd0, 32'hFFFFFFFF);
        step();
        check("x0_bypass.rd1", rd1_e, 32'd0);
        drive(32'h00000333, 1'b0, 5'd0, 32'd0);
        step();
        check("x0_read.rd1", rd1_e, 32'd0);
        check("x0_read.rd2", rd2_e, 32'd0);

        drive(32'hFFC12303, 1'b0, 5'd0, 32'd0);
        step();
        check("lw.imm", imm_e, 32'hFFFFFFFC);
        check("lw.resultsrc", {30'd0, result_src_e}, 32'd1);
        check("lw.alusrc", {31'd0, alu_src_e}, 32'd1);
        check("lw.regwrite", {31'd0, reg_write_e}, 32'd1);
        check("lw.memwrite", {31'd0, mem_write_e}, 32'd0);
        check("lw.aluctl", {29'd0, alu_ctrl_e}, 32'd0);
        check("lw.rs1", {27'd0, rs1_e}, 32'd2);
        check("lw.rd", {27'd0, rd_e}, 32'd6);

        // Flush with a live instruction; the concurrent x9 write must still land.
        flush_e = 1'b1;
        pc_d = 32'h40; pc_plus4_d = 32'h44;
        drive(32'h005283B3, 1'b1, 5'd9, 32'hA5A5A5A5);
        step();
        check_all_zero("flush");
        flush_e = 1'b0;

        // sw x5,-8(x9)
        drive(32'hFE54AC23, 1'b0, 5'd0, 32'd0);
        step();
        check("sw.memwrite", {31'd0, mem_write_e}, 32'd1);
        check("sw.regwrite", {31'd0, reg_write_e}, 32'd0);
        check("sw.alusrc", {31'd0, alu_src_e}, 32'd1);
        check("sw.imm", imm_e, 32'hFFFFFFF8);
        check("sw.rd1_x9", rd1_e, 32'hA5A5A5A5);
        check("sw.rd2_x5", rd2_e, 32'h12345678);

        // beq x0,x0,-16
        drive(32'hFE0008E3, 1'b0, 5'd0, 32'd0);
        step();
        check("beq.branch", {31'd0, branch_e}, 32'd1);
        check("beq.aluctl", {29'd0, alu_ctrl_e}, 32'd1);
        check("beq.alusrc", {31'd0, alu_src_e}, 32'd0);
        check("beq.regwrite", {31'd0, reg_write_e}, 32'd0);
        check("beq.imm", imm_e, 32'hFFFFFFF0);

        // jal x1,+2048
        drive(32'h001000EF, 1'b0, 5'd0, 32'd0);
        step();
        check("jal.jump", {31'd0, jump_e}, 32'd1);
        check("jal.regwrite", {31'd0, reg_write_e}, 32'd1);
        check("jal.resultsrc", {30'd0, result_src_e}, 32'd2);
        check("jal.imm", imm_e, 32'h00000800);
        check("jal.rd", {27'd0, rd_e}, 32'd1);

        // addi x3,x5,-1024: bit 30 set must not turn into sub.
        drive(32'hC0028193, 1'b0, 5'd0, 32'd0);
        step();
        check("addi.aluctl", {29'd0, alu_ctrl_e}, 32'd0);
        check("addi.alusrc", {31'd0, alu_src_e}, 32'd1);
        check("addi.imm", imm_e, 32'hFFFFFC00);

        drive(32'h40528233, 1'b0, 5'd0, 32'd0);
        step();
        check("sub.aluctl", {29'd0, alu_ctrl_e}, 32'd1);
        drive(32'h005222B3, 1'b0, 5'd0, 32'd0);
        step();
        check("slt.aluctl", {29'd0, alu_ctrl_e}, 32'd5);
        drive(32'h003170B3, 1'b0, 5'd0, 32'd0);
        step();
        check("and.aluctl", {29'd0, alu_ctrl_e}, 32'd2);
        drive(32'h00106093, 1'b0, 5'd0, 32'd0);
        step();
        check("ori.aluctl", {29'd0, alu_ctrl_e}, 32'd3);
        check("ori.imm", imm_e, 32'd1);

        // Mid-operation reset: E contents dropped, x5 cleared, concurrent write blocked.
        drive(32'hFFC12303, 1'b0, 5'd0, 32'd0);
        step();
        reset = 1'b0;
        drive(32'hFFC12303, 1'b1, 5'd5, 32'h00000077);
        step();
        check_all_zero("mid_reset");
        reset = 1'b1;
        drive(32'h005283B3, 1'b0, 5'd0, 32'd0);
        step();
        check("resume.regwrite", {31'd0, reg_write_e}, 32'd1);
        check("resume.rd1", rd1_e, 32'd0);
        check("resume.rd", {27'd0, rd_e}, 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
